a2d_serf: RTL and testbench
===========================

A2D_SERF -- requirements
Module: a2d_serf

Interface
REQ-001 SHALL: clk input 1 -- system clock; all state on posedge clk.
REQ-002 SHALL: rst_n input 1 -- active-low reset; asynchronous assertion; clears all state.
REQ-003 SHALL: SS_n input 1 -- SPI select from the monarch, active low, asynchronous to clk.
REQ-004 SHALL: SCLK input 1 -- SPI clock from the monarch, idle high, asynchronous to clk.
REQ-005 SHALL: MOSI input 1 -- command bits from the monarch, MSB first.
REQ-006 SHALL: MISO output 1 -- response bits to the monarch, MSB first.
REQ-007 SHALL: ana_vals input 96 -- eight 12-bit channel values; channel n occupies [12n+11:12n].
REQ-008 SHALL: cmd_ch output 3 -- channel decoded from the last good frame.
REQ-009 SHALL: cmd_vld output 1 -- one-clk pulse when a good frame completes.
REQ-010 SHALL: frame_err output 1 -- one-clk pulse when a frame ends with a bit count other than 16.

Function
REQ-011 SHALL: synchronize SS_n, SCLK and MOSI through 2 flops each.
REQ-012 SHALL: use a third flop on SS_n and SCLK for edge detection (rise = ff2 & ~ff3, fall = ~ff2 & ff3).
REQ-013 SHALL: use states IDLE and SHIFT only.
REQ-014 SHALL: in IDLE on SS_n fall, go to SHIFT, load tx_shft = {4'b0000, result}, clear bit_cnt, and clear the rx register.
REQ-015 SHALL: in SHIFT on SCLK rise, shift synchronized MOSI into rx_shft LSB and increment bit_cnt, saturating at 31.
REQ-016 SHALL: in SHIFT on SCLK fall with bit_cnt >= 1, shift tx_shft left by one; falls before the first rise are ignored.
REQ-017 SHALL: drive MISO = tx_shft[15] while in SHIFT, else 0.
REQ-018 SHALL: in SHIFT on SS_n rise, return to IDLE; if bit_cnt == 16, capture ch = rx_shft[13:11], set cmd_ch = ch, set result = ana_vals[12ch +: 12], and pulse cmd_vld the next clk; otherwise pulse frame_err and leave result and cmd_ch unchanged.
REQ-019 SHALL: ignore command bits [15:14] and [10:0].
REQ-020 SHALL: give an SS_n rise precedence over a coincident SCLK edge; that SCLK edge is ignored.
REQ-021 SHALL: ignore SCLK edges in IDLE.
REQ-022 SHALL: ignore an SS_n fall in SHIFT; no reload occurs.
REQ-023 SHALL: return conversion data one frame late: frame k returns the channel commanded in frame k-1, so the two-frame cmd/read sequence yields the commanded channel on the second frame.
REQ-024 SHALL: tolerate an SCLK half-period of at least 4 clk (system SCLK is clk/32).
REQ-025 SHALL: sample ana_vals only at good-frame end; mid-frame changes do not affect the frame in flight.

Reset
REQ-026 SHALL: on reset, set state = IDLE, result = 0, tx_shft = 0, rx_shft = 0, bit_cnt = 0, cmd_ch = 0, cmd_vld = 0, frame_err = 0, MISO = 0, and preset the SS_n/SCLK sync flops high.
REQ-027 SHALL: if reset is released with SS_n already low, stay in IDLE until an SS_n fall is seen; the partial frame produces no cmd_vld and no frame_err.

Verification
REQ-028 SHALL: ana_vals ch5 = 0xABC; frame cmd 0x2800 then frame cmd 0x2800 -> cmd_vld after each, cmd_ch = 5, second-frame MISO word = 0x0ABC.
REQ-029 SHALL: first frame after reset, cmd 0x0000 -> MISO word 0x0000, cmd_ch = 0.
REQ-030 SHALL: round robin ch0 = 0x111, ch4 = 0x444, ch5 = 0x555, ch6 = 0x666 with cmds 0x0000/0x2000/0x2800/0x3000 each sent twice -> the second frames read 0x0111, 0x0444, 0x0555, 0x0666.
REQ-031 SHALL: frame aborted after 9 SCLKs -> frame_err pulse 1 clk, no cmd_vld, next frame returns the prior result unchanged.
REQ-032 SHALL: ch6 changed from 0x7FF to 0x800 mid-frame before the end of a 0x3000 frame -> next frame returns 0x0800; a change after frame end is not seen until the next good frame.
REQ-033 SHALL: rst_n asserted mid-frame at bit 7 -> all outputs 0 immediately, no pulses, next full frame decodes normally.

Source files
------------

// File: rtl/a2d_serf.sv
// SPI serf front end for an 8-channel A2D: decodes a 16-bit channel command, returns last result.
// Latency: pulses land 3-4 clk after the SS_n/SCLK pin edge; data is returned one frame late.
// Backpressure: none; the monarch paces every frame, and ana_vals is sampled only at a good frame end.
module a2d_serf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic [95:0] ana_vals,
    output logic        MISO,
    output logic [2:0]  cmd_ch,
    output logic        cmd_vld,
    output logic        frame_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, nxt_state;
    logic [2:0]  ss_ff, sclk_ff;
    logic [1:0]  mosi_ff;
    logic [1:0]  sync_fill;
    logic [15:0] tx_shft;
    logic [13:0] rx_shft;
    logic [4:0]  bit_cnt;
    logic [11:0] result;
    logic [11:0] chan [8];

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic ld_tx, shift_rx, shift_tx, good_end, bad_end;

    // ff[0] = first stage, ff[1] = synchronized value, ff[2] = edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_ff     <= 3'b111;
            sclk_ff   <= 3'b111;
            mosi_ff   <= 2'b00;
            sync_fill <= 2'd0;
        end else begin
            ss_ff   <= {ss_ff[1:0], SS_n};
            sclk_ff <= {sclk_ff[1:0], SCLK};
            mosi_ff <= {mosi_ff[0], MOSI};
            if (sync_fill != 2'd3)
                sync_fill <= sync_fill + 2'd1;
        end
    end

    // The preset-high chain would fake an SS_n fall when reset releases with SS_n
    // already low; only trust a fall once the history flop holds a real pin sample.
    assign ss_fall   = ~ss_ff[1] &  ss_ff[2] & (sync_fill == 2'd3);
    assign ss_rise   =  ss_ff[1] & ~ss_ff[2];
    assign sclk_rise =  sclk_ff[1] & ~sclk_ff[2];
    assign sclk_fall = ~sclk_ff[1] &  sclk_ff[2];

    always_comb begin
        for (int n = 0; n < 8; n++)
            chan[n] = ana_vals[12*n +: 12];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        ld_tx     = 1'b0;
        shift_rx  = 1'b0;
        shift_tx  = 1'b0;
        good_end  = 1'b0;
        bad_end   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    nxt_state = SHIFT;
                    ld_tx     = 1'b1;
                end
            end
            SHIFT: begin
                // End of frame wins over any SCLK edge seen in the same clk
                if (ss_rise) begin
                    nxt_state = IDLE;
                    good_end  = (bit_cnt == 5'd16);
                    bad_end   = (bit_cnt != 5'd16);
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                end else if (sclk_fall && bit_cnt != 5'd0) begin
                    shift_tx = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft   <= 16'd0;
            rx_shft   <= 14'd0;
            bit_cnt   <= 5'd0;
            result    <= 12'd0;
            cmd_ch    <= 3'd0;
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cmd_vld   <= good_end;
            frame_err <= bad_end;
            if (ld_tx) begin
                tx_shft <= {4'b0000, result};
                rx_shft <= 14'd0;
                bit_cnt <= 5'd0;
            end
            if (shift_rx) begin
                rx_shft <= {rx_shft[12:0], mosi_ff[1]};
                if (bit_cnt != 5'd31)
                    bit_cnt <= bit_cnt + 5'd1;
            end
            if (shift_tx)
                tx_shft <= {tx_shft[14:0], 1'b0};
            if (good_end) begin
                cmd_ch <= rx_shft[13:11];
                result <= chan[rx_shft[13:11]];
            end
        end
    end

    assign MISO = (state == SHIFT) ? tx_shft[15] : 1'b0;

endmodule

// File: tb/tb_a2d_serf.sv
// Drives SPI frames as the monarch and scores cmd_vld/frame_err pulses, cmd_ch and returned MISO words.
module tb_a2d_serf;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [95:0] ana_vals;
    logic        MISO;
    logic [2:0]  cmd_ch;
    logic        cmd_vld;
    logic        frame_err;

    a2d_serf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .ana_vals  (ana_vals),
        .MISO      (MISO),
        .cmd_ch    (cmd_ch),
        .cmd_vld   (cmd_vld),
        .frame_err (frame_err)
    );

    typedef struct packed {
        logic        err;
        logic [2:0]  ch;
        logic [15:0] miso;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] cap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monarch-side capture of the returned word, sampled on SCLK rise
    always @(negedge SS_n) cap = 16'd0;
    always @(posedge SCLK) if (!SS_n) cap = {cap[14:0], MISO};

    // Monitor: every pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (rst_n && (cmd_vld || frame_err)) begin
            if (sbq.size() == 0) begin
                check("unexpected_pulse", {30'd0, frame_err, cmd_vld}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("pulse_kind", {30'd0, frame_err, cmd_vld}, {30'd0, e.err, ~e.err});
                check("cmd_ch", {29'd0, cmd_ch}, {29'd0, e.ch});
                if (!e.err)
                    check("miso_word", {16'd0, cap}, {16'd0, e.miso});
            end
        end
    end

    task automatic half();
        repeat (16) @(posedge clk);
    endtask

    // hook 1: change ch6 to 0x800 mid-frame; hook 2: reset mid-frame at bit 7
    task automatic frame(input logic [15:0] cmd, input int nbits, input int hook);
        SS_n = 1'b0;
        half();
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            half();
            SCLK = 1'b1;
            half();
            if (hook == 1 && i == 8)
                ana_vals[6*12 +: 12] = 12'h800;
            if (hook == 2 && i == 7) begin
                check("miso_pre_rst", {31'd0, MISO}, 32'd1);
                repeat (2) @(posedge clk);
                rst_n = 1'b0;
                #1;
                check("rst_mid_miso", {31'd0, MISO}, 32'd0);
                check("rst_mid_cmd_ch", {29'd0, cmd_ch}, 32'd0);
                check("rst_mid_pulses", {30'd0, cmd_vld, frame_err}, 32'd0);
                repeat (3) @(posedge clk);
                rst_n = 1'b1;
            end
        end
        half();
        SS_n = 1'b1;
        half();
        half();
    endtask

    task automatic run(input logic [15:0] cmd, input int nbits, input int hook,
                       input logic err, input logic [2:0] ch, input logic [15:0] miso);
        exp_t e;
        e.err  = err;
        e.ch   = ch;
        e.miso = miso;
        if (hook != 2)
            sbq.push_back(e);
        frame(cmd, nbits, hook);
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        SCLK     = 1'b1;
        MOSI     = 1'b0;
        ana_vals = '0;
        ana_vals[0*12 +: 12] = 12'h111;
        ana_vals[4*12 +: 12] = 12'h444;
        ana_vals[5*12 +: 12] = 12'hABC;
        ana_vals[6*12 +: 12] = 12'h666;
        repeat (3) @(posedge clk);
        #1;
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_cmd_ch", {29'd0, cmd_ch}, 32'd0);
        check("rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // First frame after reset, then the two-frame cmd/read of ch5
        run(16'h0000, 16, 0, 1'b0, 3'd0, 16'h0000);
        run(16'h2800, 16, 0, 1'b0, 3'd5, 16'h0111);
        run(16'h2800, 16, 0, 1'b0, 3'd5, 16'h0ABC);

        // Round robin, each command sent twice
        ana_vals[5*12 +: 12] = 12'h555;
        run(16'h0000, 16, 0, 1'b0, 3'd0, 16'h0ABC);
        run(16'h0000, 16, 0, 1'b0, 3'd0, 16'h0111);
        run(16'h2000, 16, 0, 1'b0, 3'd4, 16'h0111);
        run(16'h2000, 16, 0, 1'b0, 3'd4, 16'h0444);
        run(16'h2800, 16, 0, 1'b0, 3'd5, 16'h0444);
        run(16'h2800, 16, 0, 1'b0, 3'd5, 16'h0555);
        run(16'h3000, 16, 0, 1'b0, 3'd6, 16'h0555);
        run(16'h3000, 16, 0, 1'b0, 3'd6, 16'h0666);

        // Aborted 9-bit frame leaves result and cmd_ch alone
        run(16'h0000, 9, 0, 1'b1, 3'd6, 16'h0000);
        run(16'h3000, 16, 0, 1'b0, 3'd6, 16'h0666);

        // Bits [15:14] and [10:0] are don't-care
        run(16'hC7FF, 16, 0, 1'b0, 3'd0, 16'h0666);

        // Mid-frame ana change is captured at frame end; later change waits for next good frame
        ana_vals[6*12 +: 12] = 12'h7FF;
        run(16'h3000, 16, 1, 1'b0, 3'd6, 16'h0111);
        ana_vals[6*12 +: 12] = 12'hFFF;
        run(16'h0000, 16, 0, 1'b0, 3'd0, 16'h0800);
        run(16'h3000, 16, 0, 1'b0, 3'd6, 16'h0111);
        run(16'h3000, 16, 0, 1'b0, 3'd6, 16'h0FFF);

        // Over-long frame is an error too
        run(16'h2000, 17, 0, 1'b1, 3'd6, 16'h0000);

        // Reset in the middle of a frame, then normal decode
        run(16'h2800, 16, 2, 1'b0, 3'd0, 16'h0000);
        run(16'h2000, 16, 0, 1'b0, 3'd4, 16'h0000);
        run(16'h2000, 16, 0, 1'b0, 3'd4, 16'h0444);

        // Reset released with SS_n already low: partial frame must stay silent
        rst_n = 1'b0;
        SS_n  = 1'b0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b0;
            half();
            SCLK = 1'b1;
            half();
        end
        SS_n = 1'b1;
        half();
        half();
        run(16'h2800, 16, 0, 1'b0, 3'd5, 16'h0000);
        run(16'h2800, 16, 0, 1'b0, 3'd5, 16'h0555);

        repeat (40) @(posedge clk);
        check("sb_drained", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
